// File: rtl/mvm_bn_act_stage.sv
// Post-MVM epilogue: per-channel batch-norm scale/bias, shift quantisation,
// saturation and optional ReLU on TOUT-lane accumulator beats.
module mvm_bn_act_stage #(
    parameter int TOUT   = 8,
    parameter int ACC_DW = 32,
    parameter int DAT_DW = 16,
    parameter int BN_DW  = 16,
    parameter int AXI_DW = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            ch_groups,
    input  logic [23:0]            pix_per_group,
    input  logic                   relu_en,
    input  logic [4:0]             wt_scale,
    input  logic [4:0]             bias_scale,
    input  logic                   bn_valid,
    output logic                   bn_ready,
    input  logic [AXI_DW-1:0]      bn_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOUT*ACC_DW-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOUT*DAT_DW-1:0] out_data,
    output logic                   busy,
    output logic                   done
);
    localparam int PW = ACC_DW + BN_DW;
    localparam int YW = 56;
    localparam logic signed [YW-1:0] SAT_MAX = (56'sd1 <<< (DAT_DW - 1)) - 56'sd1;
    localparam logic signed [YW-1:0] SAT_MIN = -(56'sd1 <<< (DAT_DW - 1));

    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;
    state_t state_r, state_s;

    logic [15:0]             groups_r, grp_cnt_r;
    logic [23:0]             pix_r, pix_cnt_r;
    logic                    relu_r;
    logic [4:0]              ws_r, bs_r;
    logic [BN_DW-1:0]        w_r [TOUT];
    logic [BN_DW-1:0]        b_r [TOUT];
    logic                    s1_valid_r, out_valid_r, busy_r, done_r;
    logic signed [PW-1:0]    s1_prod_r [TOUT];
    logic [BN_DW-1:0]        s1_bias_r [TOUT];
    logic [TOUT*DAT_DW-1:0]  out_data_r, res_s;
    logic signed [PW-1:0]    prod_s [TOUT];
    logic stall_s, bn_fire_s, in_fire_s, last_pix_s, more_grp_s, zero_cfg_s;
    logic bn_ready_s, in_ready_s, busy_s, done_s;

    function automatic logic [DAT_DW-1:0] quantise(input logic signed [PW-1:0] p,
                                                   input logic [BN_DW-1:0] b,
                                                   input logic [4:0] ws, input logic [4:0] bs,
                                                   input logic relu);
        logic signed [YW-1:0] p_ext, b_ext, y;
        logic [DAT_DW-1:0]    r;
        p_ext = {{(YW-PW){p[PW-1]}}, p};
        b_ext = {{(YW-BN_DW){b[BN_DW-1]}}, b};
        y     = (p_ext >>> ws) + (b_ext <<< bs);
        if (y > SAT_MAX)      r = {1'b0, {(DAT_DW-1){1'b1}}};
        else if (y < SAT_MIN) r = {1'b1, {(DAT_DW-1){1'b0}}};
        else                  r = y[DAT_DW-1:0];
        return (relu && r[DAT_DW-1]) ? {DAT_DW{1'b0}} : r;
    endfunction

    assign stall_s    = out_valid_r && !out_ready;
    assign bn_fire_s  = bn_valid && bn_ready_s;
    assign in_fire_s  = in_valid && in_ready_s;
    assign last_pix_s = (pix_cnt_r == pix_r - 24'd1);
    assign more_grp_s = ({1'b0, grp_cnt_r} + 17'd1) < {1'b0, groups_r};
    assign zero_cfg_s = (ch_groups == 16'd0) || (pix_per_group == 24'd0);

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start) state_s = zero_cfg_s ? DONE : LOAD; else state_s = IDLE;
            LOAD:    if (bn_fire_s) state_s = RUN; else state_s = LOAD;
            RUN:     if (in_fire_s && last_pix_s) state_s = more_grp_s ? LOAD : DRAIN; else state_s = RUN;
            DRAIN:   if (!s1_valid_r && !out_valid_r) state_s = DONE; else state_s = DRAIN;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode; busy/done are derived here and registered below
    always_comb begin
        bn_ready_s = 1'b0;
        in_ready_s = 1'b0;
        case (state_r)
            LOAD:    bn_ready_s = 1'b1;
            RUN:     in_ready_s = !stall_s;
            default: in_ready_s = 1'b0;
        endcase
        busy_s = (state_s == LOAD) || (state_s == RUN) || (state_s == DRAIN);
        done_s = (state_r == DONE);
    end

    // State register, latched layer config and group/pixel counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            groups_r  <= 16'd0;
            pix_r     <= 24'd0;
            relu_r    <= 1'b0;
            ws_r      <= 5'd0;
            bs_r      <= 5'd0;
            grp_cnt_r <= 16'd0;
            pix_cnt_r <= 24'd0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            if (state_r == IDLE && start) begin
                groups_r  <= ch_groups;
                pix_r     <= pix_per_group;
                relu_r    <= relu_en;
                ws_r      <= wt_scale;
                bs_r      <= bias_scale;
                grp_cnt_r <= 16'd0;
                pix_cnt_r <= 24'd0;
            end
            if (bn_fire_s) pix_cnt_r <= 24'd0;
            if (in_fire_s) begin
                if (last_pix_s) begin
                    pix_cnt_r <= 24'd0;
                    grp_cnt_r <= grp_cnt_r + 16'd1;
                end else begin
                    pix_cnt_r <= pix_cnt_r + 24'd1;
                end
            end
        end
    end

    // BN parameter register for the current channel group
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TOUT; k++) begin
                w_r[k] <= {BN_DW{1'b0}};
                b_r[k] <= {BN_DW{1'b0}};
            end
        end else if (bn_fire_s) begin
            for (int k = 0; k < TOUT; k++) begin
                w_r[k] <= bn_data[2*BN_DW*k +: BN_DW];
                b_r[k] <= bn_data[2*BN_DW*k+BN_DW +: BN_DW];
            end
        end
    end

    // Per-lane full-width products and quantised results
    always_comb begin
        res_s = {(TOUT*DAT_DW){1'b0}};
        for (int k = 0; k < TOUT; k++) begin
            prod_s[k] = $signed({{BN_DW{in_data[ACC_DW*k+ACC_DW-1]}}, in_data[ACC_DW*k +: ACC_DW]})
                      * $signed({{ACC_DW{w_r[k][BN_DW-1]}}, w_r[k]});
            res_s[DAT_DW*k +: DAT_DW] = quantise(s1_prod_r[k], s1_bias_r[k], ws_r, bs_r, relu_r);
        end
    end

    // Two-stage datapath; the bias travels with its beat so LOAD can overwrite b_r
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {(TOUT*DAT_DW){1'b0}};
            for (int k = 0; k < TOUT; k++) begin
                s1_prod_r[k] <= {PW{1'b0}};
                s1_bias_r[k] <= {BN_DW{1'b0}};
            end
        end else if (!stall_s) begin
            s1_valid_r  <= in_fire_s;
            out_valid_r <= s1_valid_r;
            if (in_fire_s) begin
                for (int k = 0; k < TOUT; k++) begin
                    s1_prod_r[k] <= prod_s[k];
                    s1_bias_r[k] <= b_r[k];
                end
            end
            if (s1_valid_r) out_data_r <= res_s;
        end
    end

    assign bn_ready  = bn_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;
endmodule

// File: tb/tb_mvm_bn_act_stage.sv
// Directed self-checking bench for mvm_bn_act_stage with hand-computed expectations.
module tb_mvm_bn_act_stage;
    logic         clk, rst, start, relu_en, bn_valid, bn_ready, in_valid, in_ready;
    logic         out_valid, out_ready, busy, done;
    logic [15:0]  ch_groups;
    logic [23:0]  pix_per_group;
    logic [4:0]   wt_scale, bias_scale;
    logic [255:0] bn_data, in_data;
    logic [127:0] out_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    mvm_bn_act_stage dut (
        .clk(clk), .rst(rst), .start(start), .ch_groups(ch_groups), .pix_per_group(pix_per_group),
        .relu_en(relu_en), .wt_scale(wt_scale), .bias_scale(bias_scale),
        .bn_valid(bn_valid), .bn_ready(bn_ready), .bn_data(bn_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor state, written only by the monitor process
    logic [127:0] outq[$];
    int cyc = 0;
    int in_cnt, in_cyc, first_ov, bn_hs, bn_rdy_seen, done_cnt, done_cyc, start_cyc, busy_seen, max_fl;
    bit mon_clr = 1'b0;

    // Stimulus queues and hold control, written only by the main process
    logic [255:0] bn_q[$];
    logic [255:0] beat_q[$];
    int hold_grp = -1;
    int hold_cyc = 0;
    int hold_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            outq.delete();
            in_cnt = 0; in_cyc = -1; first_ov = -1; bn_hs = 0; bn_rdy_seen = 0;
            done_cnt = 0; done_cyc = -1; start_cyc = -1; busy_seen = 0; max_fl = 0;
        end else begin
            if (out_valid && out_ready) outq.push_back(out_data);
            if (in_valid && in_ready) begin in_cnt++; in_cyc = cyc; end
            if (bn_valid && bn_ready) bn_hs++;
            if (bn_ready) bn_rdy_seen++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (start) start_cyc = cyc;
            if (busy) busy_seen++;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (in_cnt - outq.size() > max_fl) max_fl = in_cnt - outq.size();
        end
    end

    function automatic logic [255:0] bn_uni(input logic [15:0] w, input logic [15:0] b);
        logic [255:0] v;
        v = 256'd0;
        for (int k = 0; k < 8; k++) begin
            v[32*k +: 16]    = w;
            v[32*k+16 +: 16] = b;
        end
        return v;
    endfunction

    function automatic logic [255:0] in_uni(input logic [31:0] x);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = x;
        return v;
    endfunction

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mon_clr = 1'b0;
        hold_grp = -1; hold_cyc = 0; hold_rdy = 0;
        bn_q.delete(); beat_q.delete();
    endtask

    // Launch a layer and feed bn_q / beat_q in order, then wait for done
    task automatic run_layer(input logic [15:0] g, input logic [23:0] p, input logic re,
                             input logic [4:0] ws, input logic [4:0] bs, output bit to);
        int n, bi;
        bit fire;
        to = 1'b0; bi = 0;
        ch_groups = g; pix_per_group = p; relu_en = re; wt_scale = ws; bias_scale = bs;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int gi = 0; gi < bn_q.size(); gi++) begin
            if (gi == hold_grp) begin
                in_valid = 1'b1; in_data = beat_q[bi];
                repeat (hold_cyc) begin
                    @(negedge clk); if (in_ready) hold_rdy++;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            bn_data = bn_q[gi]; bn_valid = 1'b1; n = 0;
            do begin @(negedge clk); fire = bn_ready; @(posedge clk); #1; n++; end while (!fire && n < 200);
            bn_valid = 1'b0;
            if (!fire) to = 1'b1;
            for (int pi = 0; pi < int'(p); pi++) begin
                in_data = beat_q[bi]; in_valid = 1'b1; n = 0;
                do begin @(negedge clk); fire = in_ready; @(posedge clk); #1; n++; end while (!fire && n < 200);
                if (!fire) to = 1'b1;
                bi++;
            end
            in_valid = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (done_cnt == 0) to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({bn_ready, in_ready, out_valid, busy, done} !== 5'b0) begin
            err_cnt++; $display("FAIL reset_ctrl: got %b expected 00000", {bn_ready, in_ready, out_valid, busy, done});
        end
        vec_cnt++;
        if (out_data !== 128'd0) begin err_cnt++; $display("FAIL reset_data: got %h expected 0", out_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        bit to;
        clr_mon();
        bn_q.push_back(bn_uni(16'd8, 16'd5));
        beat_q.push_back(in_uni(32'd100));
        run_layer(16'd1, 24'd1, 1'b0, 5'd3, 5'd2, to);
        vec_cnt++; if (to) begin err_cnt++; $display("FAIL single_timeout: got timeout expected done"); end
        vec_cnt++;
        if (outq.size() != 1 || outq[0] !== {8{16'd120}}) begin
            err_cnt++; $display("FAIL single_data: got %0d beats expected 1 beat of lanes 120", outq.size());
        end
        vec_cnt++;
        if (first_ov - in_cyc !== 2) begin err_cnt++; $display("FAIL single_latency: got %0d expected 2", first_ov - in_cyc); end
        vec_cnt++;
        if (done_cnt !== 1) begin err_cnt++; $display("FAIL single_done: got %0d expected 1", done_cnt); end
        vec_cnt++;
        if (busy_seen == 0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL single_busy: got seen=%0d end=%b expected seen>0 end=0", busy_seen, busy);
        end
    endtask

    task automatic test_saturation();
        bit to;
        int xs[8] = '{1000000, -1000000, -1, 7, -7, 100, 0, 65535};
        int ws[8] = '{1000, 1000, 1, 1, 1, -2, 5, 1};
        int bs[8] = '{0, 0, 0, 0, 0, -3, 32767, 1};
        int ex[8] = '{32767, -32768, -1, 3, -4, -103, 32767, 32767};
        logic [255:0] bw, xw;
        logic [15:0] e16;
        clr_mon();
        for (int k = 0; k < 8; k++) begin
            bw[32*k +: 16] = ws[k][15:0];
            bw[32*k+16 +: 16] = bs[k][15:0];
            xw[32*k +: 32] = xs[k];
        end
        bn_q.push_back(bw);
        beat_q.push_back(xw);
        run_layer(16'd1, 24'd1, 1'b0, 5'd1, 5'd0, to);
        vec_cnt++; if (to || outq.size() != 1) begin err_cnt++; $display("FAIL sat_count: got %0d beats expected 1", outq.size()); end
        for (int k = 0; k < 8; k++) begin
            e16 = ex[k][15:0];
            vec_cnt++;
            if (outq.size() < 1 || outq[0][16*k +: 16] !== e16) begin
                err_cnt++; $display("FAIL sat_lane%0d: got %h expected %h", k, outq.size() > 0 ? outq[0][16*k +: 16] : 16'hxxxx, e16);
            end
        end
    endtask

    task automatic test_relu();
        bit to;
        for (int r = 0; r < 2; r++) begin
            clr_mon();
            bn_q.push_back(bn_uni(16'd8, 16'd5));
            beat_q.push_back(in_uni(-32'sd100));
            run_layer(16'd1, 24'd1, (r == 0), 5'd3, 5'd2, to);
            vec_cnt++;
            if (to || outq.size() != 1 || outq[0] !== {8{(r == 0) ? 16'h0000 : 16'hFFB0}}) begin
                err_cnt++; $display("FAIL relu_%0d: got %h expected lanes %h", r, outq.size() > 0 ? outq[0] : 128'hx,
                                    (r == 0) ? 16'h0000 : 16'hFFB0);
            end
        end
    endtask

    task automatic test_multi_group();
        bit to;
        logic [15:0] v;
        clr_mon();
        for (int g = 0; g < 3; g++) bn_q.push_back(bn_uni(16'(g + 1), 16'd0));
        for (int j = 0; j < 12; j++) beat_q.push_back(in_uni(32'd16));
        hold_grp = 1; hold_cyc = 5;
        run_layer(16'd3, 24'd4, 1'b0, 5'd0, 5'd0, to);
        vec_cnt++; if (to) begin err_cnt++; $display("FAIL multi_timeout: got timeout expected done"); end
        vec_cnt++; if (outq.size() != 12) begin err_cnt++; $display("FAIL multi_count: got %0d expected 12", outq.size()); end
        for (int j = 0; j < 12 && j < outq.size(); j++) begin
            v = 16'(16 * (j / 4 + 1));
            vec_cnt++;
            if (outq[j] !== {8{v}}) begin err_cnt++; $display("FAIL multi_beat%0d: got %h expected lanes %0d", j, outq[j], v); end
        end
        vec_cnt++; if (bn_hs !== 3) begin err_cnt++; $display("FAIL multi_bn_hs: got %0d expected 3", bn_hs); end
        vec_cnt++; if (hold_rdy !== 0) begin err_cnt++; $display("FAIL multi_hold_ready: got %0d expected 0", hold_rdy); end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [127:0] held;
        logic [15:0] v;
        clr_mon();
        bn_q.push_back(bn_uni(16'd3, 16'd1));
        for (int i = 0; i < 8; i++) beat_q.push_back(in_uni(32'(10 * i + 3)));
        fork
            run_layer(16'd1, 24'd8, 1'b0, 5'd1, 5'd0, to);
            begin
                int n = 0;
                while (outq.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
                out_ready = 1'b0;
                held = out_data;
                vec_cnt++;
                if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid_at_stall: got %b expected 1", out_valid); end
                repeat (6) begin
                    @(posedge clk); #1;
                    vec_cnt++;
                    if (out_valid !== 1'b1 || out_data !== held) begin
                        err_cnt++; $display("FAIL bp_hold: got %b/%h expected 1/%h", out_valid, out_data, held);
                    end
                end
                out_ready = 1'b1;
            end
        join
        vec_cnt++; if (to) begin err_cnt++; $display("FAIL bp_timeout: got timeout expected done"); end
        vec_cnt++; if (outq.size() != 8) begin err_cnt++; $display("FAIL bp_count: got %0d expected 8", outq.size()); end
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            v = 16'(5 + 15 * i);
            vec_cnt++;
            if (outq[i] !== {8{v}}) begin err_cnt++; $display("FAIL bp_beat%0d: got %h expected lanes %0d", i, outq[i], v); end
        end
        vec_cnt++; if (max_fl > 2) begin err_cnt++; $display("FAIL bp_inflight: got %0d expected <=2", max_fl); end
    endtask

    task automatic test_zero_groups();
        bit to;
        clr_mon();
        run_layer(16'd0, 24'd4, 1'b0, 5'd0, 5'd0, to);
        vec_cnt++; if (to || done_cnt !== 1) begin err_cnt++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
        vec_cnt++;
        if (done_cyc - start_cyc !== 2) begin err_cnt++; $display("FAIL zero_latency: got %0d expected 2", done_cyc - start_cyc); end
        vec_cnt++; if (bn_rdy_seen !== 0) begin err_cnt++; $display("FAIL zero_bn_ready: got %0d expected 0", bn_rdy_seen); end
        vec_cnt++; if (outq.size() != 0) begin err_cnt++; $display("FAIL zero_outputs: got %0d expected 0", outq.size()); end
    endtask

    task automatic test_mid_reset();
        bit to, fire;
        int n;
        clr_mon();
        ch_groups = 16'd1; pix_per_group = 24'd8; relu_en = 1'b0; wt_scale = 5'd3; bias_scale = 5'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bn_data = bn_uni(16'd8, 16'd5); bn_valid = 1'b1; n = 0;
        do begin @(negedge clk); fire = bn_ready; @(posedge clk); #1; n++; end while (!fire && n < 50);
        bn_valid = 1'b0;
        in_data = in_uni(32'd100); in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL midrst_pre: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({bn_ready, in_ready, out_valid, busy, done} !== 5'b0 || out_data !== 128'd0) begin
            err_cnt++; $display("FAIL midrst_clear: got %b/%h expected 00000/0", {bn_ready, in_ready, out_valid, busy, done}, out_data);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        vec_cnt++; if (done_cnt !== 0) begin err_cnt++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt); end
        clr_mon();
        bn_q.push_back(bn_uni(16'd8, 16'd5));
        beat_q.push_back(in_uni(32'd100));
        run_layer(16'd1, 24'd1, 1'b0, 5'd3, 5'd2, to);
        vec_cnt++;
        if (to || outq.size() != 1 || outq[0] !== {8{16'd120}} || done_cnt !== 1) begin
            err_cnt++; $display("FAIL midrst_rerun: got %0d beats done=%0d expected 1 beat of 120 done=1", outq.size(), done_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ch_groups = 16'd0; pix_per_group = 24'd0; relu_en = 1'b0;
        wt_scale = 5'd0; bias_scale = 5'd0; bn_valid = 1'b0; bn_data = 256'd0;
        in_valid = 1'b0; in_data = 256'd0; out_ready = 1'b1;
        test_reset();
        test_single_beat();
        test_saturation();
        test_relu();
        test_multi_group();
        test_backpressure();
        test_zero_groups();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/mvm_bn_act_stage.md
Name: mvm_bn_act_stage

Overview:
- Post-MVM epilogue stage. Sits directly downstream of the HBM MVM accumulator array.
- Consumes Tout-wide signed accumulator beats and applies per-channel batch-norm scale and bias.
- Shift-quantises, saturates and optionally applies ReLU, then hands Tout-wide activations to the output DMA writer.
- BN weight/bias words are pulled from the BN parameter read stream, one word per channel group.

Parameters:
- TOUT, 8, channel lanes per beat.
- ACC_DW, 32, signed accumulator width per lane.
- DAT_DW, 16, signed output activation width per lane.
- BN_DW, 16, signed BN weight and bias width.
- AXI_DW, 256, BN word width. Must equal TOUT*2*BN_DW.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse that launches a layer.
- ch_groups, in, 16, number of Tout channel groups (CHout_Padding/Tout).
- pix_per_group, in, 24, number of beats per group (Hout*Wout).
- relu_en, in, 1, enables ReLU.
- wt_scale, in, 5, right-shift applied to x*w.
- bias_scale, in, 5, left-shift applied to the bias.
- bn_valid / bn_ready, in / out, 1 / 1, BN word handshake.
- bn_data, in, AXI_DW, lane k: weight at [2*BN_DW*k +: BN_DW], bias at [2*BN_DW*k+BN_DW +: BN_DW].
- in_valid / in_ready, in / out, 1 / 1, accumulator handshake.
- in_data, in, TOUT*ACC_DW, lane k at [ACC_DW*k +: ACC_DW].
- out_valid / out_ready, out / in, 1 / 1, result handshake.
- out_data, out, TOUT*DAT_DW, lane k at [DAT_DW*k +: DAT_DW].
- busy, out, 1, high from the cycle after start until done.
- done, out, 1, one-cycle pulse.

Behaviour:
- Reset: FSM=IDLE. bn_ready, in_ready, out_valid, busy, done = 0. out_data = 0. Pipeline valids and counters cleared. Asserting rst mid-layer aborts the layer; no done pulse is issued.
- start is sampled in IDLE only. Config inputs are latched on start. start while busy is ignored.
- FSM states:
  - IDLE -> LOAD on start when ch_groups != 0 and pix_per_group != 0. If either is 0: DONE directly, no BN fetch.
  - LOAD: bn_ready = 1. On bn_valid&&bn_ready, latch the TOUT weight/bias pairs into the param register, clear pix_cnt, go to RUN.
  - RUN: accept beats. After the last beat of a group is accepted: if grp_cnt+1 < ch_groups, go to LOAD; else go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the last out beat has been accepted, then go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- A LOAD for the next group may proceed while earlier beats are still in the pipeline. Each stage carries its own copy of the weights/bias, so the param register may be overwritten.
- Pipeline: 2 stages with a global stall, stall = out_valid && !out_ready.
  - in_ready = (state==RUN) && !stall.
  - Stage 1: p = x*w, full 48-bit signed product per lane.
  - Stage 2: y = (p >>> wt_scale) + (sext(b) <<< bias_scale), computed in 56-bit signed.
- Latency: a beat accepted at cycle t appears with out_valid at t+2 when not stalled. Sustained throughput is 1 beat/clk.
- Arithmetic:
  - Right shift is arithmetic, i.e. floor.
  - Saturate y to [-2^(DAT_DW-1), 2^(DAT_DW-1)-1].
  - ReLU is applied after saturation: if relu_en and y<0, y = 0.
- out_data and out_valid hold stable while stalled.
- Beat order is group-major: g = 0..ch_groups-1, pixel 0..pix_per_group-1 within each group.
- Extra in_valid beats outside RUN are not accepted.

Test Plan:
1. Single beat, 1 group, 1 pixel. Config: wt_scale=3, bias_scale=2, relu_en=0. Every lane w=8, b=5, x=100. -> out lane = 800>>>3 + 20 = 120; out_valid at accept+2; done pulses once the beat is accepted.
2. Saturation and floor, lanes set as follows:
   - x=1000000, w=1000 -> 32767.
   - x=-1000000, w=1000 -> -32768.
   - x=-1, w=1, wt_scale=1, b=0 -> -1 (floor).
3. ReLU, x=-100, w=8, b=5, scales 3/2 -> y = -80. relu_en=1 gives 0; relu_en=0 gives 0xFFB0.
4. Multi-group: ch_groups=3, pix_per_group=4. Group g has w=g+1, b=0. x=16, wt_scale=0. -> 12 outputs: 16,16,16,16, then 32×4, then 48×4. Exactly 3 BN handshakes. The BN word for group 1 is withheld 5 cycles, and in_ready stays low during that time.
5. Backpressure: hold out_ready=0 for 6 cycles mid-stream. -> At most 2 beats are in flight; out_data is stable while stalled; no loss or duplication; order is preserved.
6. Edge cases:
   - ch_groups=0 -> done 2 cycles after start, no bn_ready.
   - rst pulsed mid-RUN -> all outputs return to 0, no done; a fresh start runs normally.
